vid_timing_gen: RTL and testbench

Programmable, parametrised video timing generator for the vid5 display path. It owns the controller register file (CR, H1, H2, V1, V2), which is written over the command bus, and produces pixel-rate horizontal and vertical counters, sync, blank and data-enable strobes. It adds several features over the first-generation controller:
- generic counter width
- pixel-clock divider
- sync polarity control
- shadowed registers that take effect only at frame boundaries, so reprogramming never tears a frame

---
 rtl/vid_timing_gen.sv | 166 ++++++++++++++++
 tb/tb_vid_timing_gen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_timing_gen.sv
// Video timing generator: command-bus register file (shadow + active copies),
// pixel-clock divider, h/v counters and registered sync/blank/de strobes.
module vid_timing_gen #(
  parameter int CW = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          selin,
  input  logic [2:0]    cmdin,
  input  logic [31:0]   addrdatain,
  output logic          ackout,
  output logic          hsync,
  output logic          hblank,
  output logic          vsync,
  output logic          vblank,
  output logic          de,
  output logic          frame_start,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount
);

  typedef enum logic {W_IDLE, W_DATA} wstate_t;

  typedef struct packed {
    logic          en;
    logic [5:0]    pcnt;
    logic          hpol;
    logic          vpol;
    logic [CW-1:0] hend;
    logic [CW-1:0] hsize;
    logic [CW-1:0] hs_end;
    logic [CW-1:0] hs_start;
    logic [CW-1:0] vend;
    logic [CW-1:0] vsize;
    logic [CW-1:0] vs_end;
    logic [CW-1:0] vs_start;
  } regs_t;

  wstate_t       state, state_n;
  logic [7:0]    offset;
  logic          wr_en;
  regs_t         sh, sh_n, act, act_n;
  logic [5:0]    div, div_n;
  logic          tick, wrap;
  logic [CW-1:0] h_n, v_n;
  logic          unused_data;

  // Only the offset byte and the field bits carry meaning on the bus.
  assign unused_data = ^addrdatain;

  // Bus write sequencing: address phase arms, data phase commits.
  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    case (state)
      W_IDLE: if (selin && cmdin == 3'b100) state_n = W_DATA;
      W_DATA: if (selin) begin
        wr_en   = 1'b1;
        state_n = W_IDLE;
      end
      default: state_n = W_IDLE;
    endcase
  end

  // Bus state, latched offset and acknowledge pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= W_IDLE;
      offset <= '0;
      ackout <= 1'b0;
    end else begin
      state  <= state_n;
      ackout <= wr_en;
      if (state == W_IDLE && state_n == W_DATA) offset <= addrdatain[7:0];
    end
  end

  // Shadow register update from a committed data phase; unknown offsets drop.
  always_comb begin
    sh_n = sh;
    if (wr_en) begin
      case (offset)
        8'h00: begin
          sh_n.en   = addrdatain[3];
          sh_n.pcnt = addrdatain[9:4];
          sh_n.hpol = addrdatain[10];
          sh_n.vpol = addrdatain[11];
        end
        8'h28: begin
          sh_n.hend  = addrdatain[CW-1:0];
          sh_n.hsize = addrdatain[2*CW-1:CW];
        end
        8'h30: begin
          sh_n.hs_end   = addrdatain[CW-1:0];
          sh_n.hs_start = addrdatain[2*CW-1:CW];
        end
        8'h38: begin
          sh_n.vend  = addrdatain[CW-1:0];
          sh_n.vsize = addrdatain[2*CW-1:CW];
        end
        8'h40: begin
          sh_n.vs_end   = addrdatain[CW-1:0];
          sh_n.vs_start = addrdatain[2*CW-1:CW];
        end
        default: ;
      endcase
    end
  end

  // Divider, counters and active-register reload.
  // While disabled the active copy tracks the incoming shadow value so an
  // enable takes effect the cycle after its data phase; at the wrap tick the
  // old shadow value is taken so a coincident write waits a frame.
  always_comb begin
    tick  = act.en && (div == act.pcnt);
    wrap  = tick && (hcount == act.hend) && (vcount == act.vend);
    act_n = act;
    if (!act.en)   act_n = sh_n;
    else if (wrap) act_n = sh;
    div_n = (!act.en || tick) ? '0 : div + 6'd1;
    h_n   = hcount;
    v_n   = vcount;
    if (!act_n.en) begin
      h_n = '0;
      v_n = '0;
    end else if (tick) begin
      if (hcount == act.hend) begin
        h_n = '0;
        v_n = (vcount == act.vend) ? '0 : vcount + 1'b1;
      end else begin
        h_n = hcount + 1'b1;
      end
    end
  end

  // State registers; strobes are decoded from next-state values so they
  // line up with the registered counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh          <= '0;
      act         <= '0;
      div         <= '0;
      hcount      <= '0;
      vcount      <= '0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sh          <= sh_n;
      act         <= act_n;
      div         <= div_n;
      hcount      <= h_n;
      vcount      <= v_n;
      hblank      <= !act_n.en || (h_n >= act_n.hsize);
      vblank      <= !act_n.en || (v_n >= act_n.vsize);
      hsync       <= act_n.hpol ^ (act_n.en && (act_n.hs_start <= h_n) && (h_n < act_n.hs_end));
      vsync       <= act_n.vpol ^ (act_n.en && (act_n.vs_start <= v_n) && (v_n < act_n.vs_end));
      de          <= act_n.en && (h_n < act_n.hsize) && (v_n < act_n.vsize);
      frame_start <= wrap && act_n.en;
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: frame-position reference model plus literal checks.
module tb_vid_timing_gen;
  localparam int CW = 13;
  localparam logic [31:0] MASK = (32'd1 << CW) - 32'd1;
  localparam int VW = 2*CW + 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          selin = 1'b0;
  logic [2:0]    cmdin = '0;
  logic [31:0]   addrdatain = '0;
  logic          ackout, hsync, hblank, vsync, vblank, de, frame_start;
  logic [CW-1:0] hcount, vcount;

  vid_timing_gen #(.CW(CW)) dut (
    .clk(clk), .reset(reset), .selin(selin), .cmdin(cmdin), .addrdatain(addrdatain),
    .ackout(ackout), .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
    .de(de), .frame_start(frame_start), .hcount(hcount), .vcount(vcount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en; int pcnt; bit hpol; bit vpol;
    int hend; int hsize; int hs_end; int hs_start;
    int vend; int vsize; int vs_end; int vs_start;
  } cfg_t;

  cfg_t       cfg_zero, m_sh, m_act;
  bit         m_data, m_ack, m_fs;
  logic [7:0] m_off = '0;
  longint     m_t = 0;
  longint     cyc = 0;
  int         n_checks = 0, n_fail = 0;
  int         fs_q[$], de_q[$], hs_q[$];
  int         de_run = 0, hs_run = 0;
  logic [CW-1:0] h_at_ack, h_after;

  function automatic logic [31:0] pack2(int lo, int hi);
    return (32'(hi) << CW) | 32'(lo);
  endfunction

  function automatic cfg_t apply_write(cfg_t c, logic [7:0] off, logic [31:0] d);
    int lo, hi;
    lo = int'(d & MASK);
    hi = int'((d >> CW) & MASK);
    case (off)
      8'h00: begin c.en = d[3]; c.pcnt = int'(d[9:4]); c.hpol = d[10]; c.vpol = d[11]; end
      8'h28: begin c.hend = lo;   c.hsize = hi;    end
      8'h30: begin c.hs_end = lo; c.hs_start = hi; end
      8'h38: begin c.vend = lo;   c.vsize = hi;    end
      8'h40: begin c.vs_end = lo; c.vs_start = hi; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic longint period(cfg_t c);
    return longint'(c.hend + 1) * longint'(c.vend + 1) * longint'(c.pcnt + 1);
  endfunction

  task automatic model_reset();
    m_sh = cfg_zero; m_act = cfg_zero;
    m_data = 0; m_ack = 0; m_fs = 0; m_t = 0; m_off = '0;
  endtask

  // One clock of the reference: bus protocol, shadow/active copies, frame position.
  task automatic model_step();
    bit   wr;
    cfg_t sh2;
    wr  = m_data && selin;
    sh2 = m_sh;
    if (wr) sh2 = apply_write(m_sh, m_off, addrdatain);
    if (!m_data) begin
      if (selin && cmdin == 3'b100) begin m_data = 1; m_off = addrdatain[7:0]; end
    end else if (selin) begin
      m_data = 0;
    end
    m_ack = wr;
    m_fs  = 0;
    if (!m_act.en) begin
      m_act = sh2; m_t = 0;
    end else if (m_t == period(m_act) - 1) begin
      m_act = m_sh; m_t = 0; m_fs = m_act.en;
    end else begin
      m_t++;
    end
    m_sh = sh2;
  endtask

  // Outputs follow from the pixel index within the frame.
  function automatic logic [VW-1:0] expect_vec();
    int p, h, v;
    bit hb, vb, hs, vs, den;
    if (!m_act.en) begin
      h = 0; v = 0; hb = 1; vb = 1; hs = m_act.hpol; vs = m_act.vpol;
    end else begin
      p  = int'(m_t / longint'(m_act.pcnt + 1));
      h  = p % (m_act.hend + 1);
      v  = p / (m_act.hend + 1);
      hb = h >= m_act.hsize;
      vb = v >= m_act.vsize;
      hs = ((m_act.hs_start <= h) && (h < m_act.hs_end)) ^ m_act.hpol;
      vs = ((m_act.vs_start <= v) && (v < m_act.vs_end)) ^ m_act.vpol;
    end
    den = !hb && !vb;
    return {m_ack, m_fs, den, hs, hb, vs, vb, CW'(h), CW'(v)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {ackout, frame_start, de, hsync, hblank, vsync, vblank, hcount, vcount};
  endfunction

  task automatic check_lit(string name, longint got, longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) model_reset();
    else model_step();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle comparison against the reference.
  initial forever begin
    logic [VW-1:0] got, exp;
    @(negedge clk);
    got = dut_vec();
    exp = expect_vec();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL cycle_compare cyc=%0d got=%h expected=%h", cyc, got, exp);
    end
  end

  // Frame-start timestamps and per-frame de/hsync counts.
  initial forever begin
    @(negedge clk);
    if (frame_start === 1'b1) begin
      fs_q.push_back(int'(cyc)); de_q.push_back(de_run); hs_q.push_back(hs_run);
      de_run = int'(de); hs_run = int'(hsync);
    end else begin
      de_run += int'(de); hs_run += int'(hsync);
    end
  end

  task automatic clear_q();
    fs_q.delete(); de_q.delete(); hs_q.delete();
  endtask

  task automatic wait_fs(input int n, output bit ok);
    int b = 0;
    while (fs_q.size() < n && b < 3000) begin @(negedge clk); b++; end
    ok = fs_q.size() >= n;
    if (!ok) check_lit("frame_start_timeout", fs_q.size(), n);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      selin = ($urandom_range(0, 3) == 0);
      cmdin = 3'($urandom_range(0, 3));
      addrdatain = $urandom;
    end
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [31:0] d, input int gap);
    @(posedge clk); #1;
    selin = 1'b1; cmdin = 3'b100; addrdatain = {24'($urandom), off};
    repeat (gap) begin
      @(posedge clk); #1;
      selin = 1'b0; cmdin = 3'($urandom); addrdatain = $urandom;
    end
    @(posedge clk); #1;
    selin = 1'b1; cmdin = 3'($urandom); addrdatain = d;
    @(posedge clk); #1;
    check_lit("ack_pulse", longint'(ackout), 1);
    h_at_ack = hcount;
    selin = 1'b0; cmdin = '0;
    @(posedge clk); #1;
    check_lit("ack_clear", longint'(ackout), 0);
    h_after = hcount;
  endtask

  initial begin
    bit ok;
    int b;
    logic [VW-1:0] rst_vec;
    rst_vec = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, {CW{1'b0}}, {CW{1'b0}}};

    #2 reset = 1'b0;
    @(negedge clk);
    check_lit("reset_values", longint'(dut_vec()), longint'(rst_vec));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // 6x4 geometry, pcnt=0
    bus_write(8'h28, pack2(5, 4), 0);
    bus_write(8'h30, pack2(5, 4), 0);
    bus_write(8'h38, pack2(3, 2), 0);
    bus_write(8'h40, pack2(3, 2), 0);
    bus_write(8'h00, 32'h8, 0);
    check_lit("enable_first_count", longint'(h_at_ack), 0);
    check_lit("enable_next_count", longint'(h_after), 1);
    clear_q();
    wait_fs(3, ok);
    if (ok) begin
      check_lit("frame_len_pcnt0", fs_q[2] - fs_q[1], 24);
      check_lit("de_per_frame", de_q[2], 8);
      check_lit("hsync_per_frame", hs_q[2], 4);
    end

    // divider pcnt=2
    bus_write(8'h00, 32'h28, 0);
    clear_q();
    wait_fs(3, ok);
    if (ok) check_lit("frame_len_pcnt2", fs_q[2] - fs_q[1], 72);

    // mid-frame H1 rewrite takes effect at the next frame
    clear_q();
    wait_fs(1, ok);
    idle(3);
    bus_write(8'h28, pack2(7, 4), 0);
    wait_fs(3, ok);
    if (ok) begin
      check_lit("frame_len_keep", fs_q[1] - fs_q[0], 72);
      check_lit("frame_len_new", fs_q[2] - fs_q[1], 96);
    end

    // gapped write, then an unmapped offset
    bus_write(8'h40, pack2(3, 1), 3);
    bus_write(8'h44, $urandom, 0);
    idle(20);

    // hend=0, vend=0: one-cycle frames
    bus_write(8'h28, pack2(0, 1), 0);
    bus_write(8'h38, pack2(0, 1), 0);
    bus_write(8'h00, 32'h8, 0);
    clear_q();
    wait_fs(4, ok);
    if (ok) check_lit("frame_len_min", fs_q[3] - fs_q[2], 1);

    // randomized register traffic
    for (int i = 0; i < 150; i++) begin
      logic [7:0]  off;
      logic [31:0] d;
      case ($urandom_range(0, 5))
        0: begin
          off = 8'h00;
          d = ($urandom & 32'hFFFF_FC07) | (32'($urandom_range(0, 3)) << 4) |
              (($urandom_range(0, 3) != 0) ? 32'h8 : 32'h0);
        end
        1: begin off = 8'h28; d = pack2($urandom_range(0, 7), $urandom_range(0, 9)); end
        2: begin off = 8'h30; d = pack2($urandom_range(0, 9), $urandom_range(0, 9)); end
        3: begin off = 8'h38; d = pack2($urandom_range(0, 5), $urandom_range(0, 7)); end
        4: begin off = 8'h40; d = pack2($urandom_range(0, 7), $urandom_range(0, 7)); end
        default: begin
          off = 8'($urandom);
          if (off inside {8'h00, 8'h28, 8'h30, 8'h38, 8'h40}) off = 8'h44;
          d = $urandom;
        end
      endcase
      bus_write(off, d, $urandom_range(0, 2));
      idle($urandom_range(0, 20));
    end

    // inverted syncs, then asynchronous reset mid-line during a write
    bus_write(8'h28, pack2(5, 4), 0);
    bus_write(8'h30, pack2(5, 4), 0);
    bus_write(8'h38, pack2(3, 2), 0);
    bus_write(8'h40, pack2(3, 2), 0);
    bus_write(8'h00, 32'hC08, 0);
    clear_q();
    wait_fs(3, ok);
    b = 0;
    while (hcount != CW'(1) && b < 200) begin @(negedge clk); b++; end
    check_lit("find_hcount1", longint'(hcount), 1);
    @(posedge clk); #1;
    selin = 1'b1; cmdin = 3'b100; addrdatain = 32'h28;
    @(posedge clk); #1;
    selin = 1'b0; cmdin = '0;
    check_lit("hsync_inverted_idle", longint'(hsync), 1);
    #2 reset = 1'b0;
    #1 check_lit("reset_midline", longint'(dut_vec()), longint'(rst_vec));
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    selin = 1'b1; cmdin = '0; addrdatain = 32'h00FF_FFFF;
    @(posedge clk); #1;
    selin = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
